restoring_divider: RTL

RESTORING_DIVIDER -- requirements
Module: restoring_divider

---
 rtl/restoring_divider_pkg.sv | 12 +
 rtl/div_step.sv | 25 ++
 rtl/restoring_divider.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/restoring_divider_pkg.sv
// Shared constants for the restoring divider: FSM state encoding and default operand width.
package restoring_divider_pkg;

    localparam int DEFAULT_SIZE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: trial subtract, restore select and quotient bit.
module div_step #(
    parameter int SIZE = 4
) (
    input  logic [SIZE:0]   partial,
    input  logic [SIZE-1:0] divisor,
    output logic [SIZE-1:0] remainder,
    output logic            quotient_bit
);

    logic [SIZE:0] diff_s;

    // The partial is always below twice the divisor, so the (SIZE+1)-bit difference never overflows and its MSB is the sign.
    always_comb begin
        diff_s = partial - {1'b0, divisor};
        if (diff_s[SIZE]) begin
            remainder    = partial[SIZE-1:0];
            quotient_bit = 1'b0;
        end else begin
            remainder    = diff_s[SIZE-1:0];
            quotient_bit = 1'b1;
        end
    end

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, results held until the next division.
module restoring_divider
    import restoring_divider_pkg::*;
#(
    parameter int SIZE = DEFAULT_SIZE
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            iStart,
    input  logic [SIZE-1:0] iDividend,
    input  logic [SIZE-1:0] iDivisor,
    output logic [SIZE-1:0] oQuotient,
    output logic [SIZE-1:0] oRemainder,
    output logic            oBusy,
    output logic            oDone,
    output logic            oDivByZero
);

    localparam int CNT_W = $clog2(SIZE);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(SIZE - 1);

    state_t            state_r;
    state_t            state_next_s;
    logic [CNT_W-1:0]  count_r;
    logic [SIZE-1:0]   rem_r;
    logic [SIZE-1:0]   dvd_r;
    logic [SIZE-1:0]   dvs_r;
    logic [SIZE-1:0]   quotient_r;
    logic [SIZE-1:0]   remainder_r;
    logic              dbz_r;
    logic [SIZE:0]     shifted_s;
    logic [SIZE-1:0]   rem_next_s;
    logic [SIZE-1:0]   quot_next_s;
    logic              q_bit_s;
    logic              busy_s;
    logic              done_s;

    // The dividend register doubles as the quotient shift register.
    assign shifted_s   = {rem_r, dvd_r[SIZE-1]};
    assign quot_next_s = {dvd_r[SIZE-2:0], q_bit_s};

    div_step #(.SIZE(SIZE)) u_step (
        .partial      (shifted_s),
        .divisor      (dvs_r),
        .remainder    (rem_next_s),
        .quotient_bit (q_bit_s)
    );

    // State register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a zero divisor spends a single CALC cycle so its result arrives two edges after start.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (iStart) begin
                    state_next_s = CALC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CALC: begin
                if ((dvs_r == {SIZE{1'b0}}) || (count_r == LAST_STEP)) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = CALC;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Status decode from the registered state.
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_r)
            CALC:    busy_s = 1'b1;
            DONE:    done_s = 1'b1;
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count_r     <= {CNT_W{1'b0}};
            rem_r       <= {SIZE{1'b0}};
            dvd_r       <= {SIZE{1'b0}};
            dvs_r       <= {SIZE{1'b0}};
            quotient_r  <= {SIZE{1'b0}};
            remainder_r <= {SIZE{1'b0}};
            dbz_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (iStart) begin
                        dvd_r   <= iDividend;
                        dvs_r   <= iDivisor;
                        rem_r   <= {SIZE{1'b0}};
                        count_r <= {CNT_W{1'b0}};
                        if (iDivisor != {SIZE{1'b0}}) begin
                            dbz_r <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    if (dvs_r == {SIZE{1'b0}}) begin
                        quotient_r  <= {SIZE{1'b1}};
                        remainder_r <= dvd_r;
                        dbz_r       <= 1'b1;
                    end else begin
                        rem_r <= rem_next_s;
                        dvd_r <= quot_next_s;
                        if (count_r == LAST_STEP) begin
                            quotient_r  <= quot_next_s;
                            remainder_r <= rem_next_s;
                        end else begin
                            count_r <= count_r + CNT_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign oQuotient  = quotient_r;
    assign oRemainder = remainder_r;
    assign oDivByZero = dbz_r;
    assign oBusy      = busy_s;
    assign oDone      = done_s;

endmodule
